// File: rtl/pb_input_pio_pkg.sv
// Shared constants for the pushbutton input port: register map and the released-button level.
package pb_input_pkg;

  localparam logic [1:0] PB_ADDR_DATA = 2'd0;
  localparam logic [1:0] PB_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PB_ADDR_MASK = 2'd2;
  localparam logic [1:0] PB_ADDR_EDGE = 2'd3;

  // Buttons are active-low, so an idle line reads as 1.
  localparam logic PB_RELEASED = 1'b1;

endpackage

// File: rtl/pb_input_pio_if.sv
// Avalon-MM slave bus bundle for the pushbutton input port.
// Handshake: zero-wait-state Avalon; a transfer happens in every cycle chipselect is high
// (write when write_n is low, read otherwise), there is no waitrequest and readdata is valid
// in the same cycle.
interface pb_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/pb_input_pio_debounce.sv
// One-bit pushbutton synchroniser plus optional debounce filter.
// Optional feature: PB_INPUT_DEBOUNCE_EN builds the stability counter; otherwise stable follows sync.
module pb_debounce
  import pb_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_r <= {SYNC_STAGES{PB_RELEASED}};
    else          sync_r <= {sync_r[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_r[SYNC_STAGES-1];

`ifdef PB_INPUT_DEBOUNCE_EN
  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             stable_r;

  // Counter only runs while sync disagrees with stable; any agreeing cycle restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      stable_r <= PB_RELEASED;
    end else if (sync != stable_r) begin
      if (cnt >= CNT_MAX) begin
        stable_r <= sync;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign stable = stable_r;
`else
  assign stable = sync;
`endif

endmodule

// File: rtl/pb_input_pio.sv
// Pushbutton input PIO: synchronise/debounce, sticky falling-edge capture, masked level IRQ.
// Build option PB_INPUT_DEBOUNCE_EN enables the per-bit debounce filter inside pb_debounce.
module pb_input_pio
  import pb_input_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  pb_input_pio_if.slave    bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    pb_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign edge_clr     = (wr_en && bus.address == PB_ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  assign fall         = prev & ~stable;
  assign unused_wdata = ^bus.writedata;

  // A new falling edge is OR-ed in after the clear, so it survives a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= {WIDTH{PB_RELEASED}};
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= stable;
      edge_cap <= (edge_cap & ~edge_clr) | fall;
      if (wr_en && bus.address == PB_ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (reset_n && bus.chipselect) begin
      unique case (bus.address)
        PB_ADDR_DATA: bus.readdata[WIDTH-1:0] = stable;
        PB_ADDR_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
        PB_ADDR_EDGE: bus.readdata[WIDTH-1:0] = edge_cap;
        default:      bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_input_pio.sv
// Testbench for pb_input_pio (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8), with or without
// PB_INPUT_DEBOUNCE_EN; register table, directed corner sequences and a random run vs a model.
module tb_pb_input_pio;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef PB_INPUT_DEBOUNCE_EN
  localparam int DLAT = DEB;
`else
  localparam int DLAT = 0;
`endif
  localparam int LAT  = SYNC + DLAT + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = 4'hF;
  logic         irq;

  pb_input_pio_if bus_if ();

  pb_input_pio #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Button lines are tracked as histories: the synchronised value is the raw sample SYNC-1
  // edges back; with debounce a level is accepted once it has been seen opposite the
  // accepted level for DEB samples in a row.
  logic [W-1:0] raw_q[$];
  logic [W-1:0] sync_q[$];
  logic [W-1:0] stab_q[$];
  logic [W-1:0] m_ecap;
  logic [W-1:0] m_mask;
  logic         m_irq;

  task automatic model_reset();
    raw_q = {};  sync_q = {};  stab_q = {};
    repeat (SYNC) raw_q.push_back(4'hF);
    repeat (DEB)  sync_q.push_back(4'hF);
    stab_q.push_back(4'hF);
    stab_q.push_back(4'hF);
    m_ecap = '0;  m_mask = '0;  m_irq = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] in_v, input logic we,
                            input logic [1:0] wa, input logic [31:0] wd);
    logic [W-1:0] s, cur, older, nxt, clr;
    raw_q.push_back(in_v);
    s = raw_q[raw_q.size() - SYNC];
    void'(raw_q.pop_front());
    cur   = stab_q[1];
    older = stab_q[0];
`ifdef PB_INPUT_DEBOUNCE_EN
    nxt = cur;
    for (int b = 0; b < W; b++) begin
      bit all_opp = 1'b1;
      foreach (sync_q[k]) if (sync_q[k][b] == cur[b]) all_opp = 1'b0;
      if (all_opp) nxt[b] = ~cur[b];
    end
    sync_q.push_back(s);
    void'(sync_q.pop_front());
`else
    nxt = s;
`endif
    clr    = (we && wa == 2'd3) ? wd[W-1:0] : '0;
    m_irq  = |(m_ecap & m_mask);
    m_ecap = (m_ecap & ~clr) | (older & ~cur);
    if (we && wa == 2'd2) m_mask = wd[W-1:0];
    stab_q.push_back(nxt);
    void'(stab_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [W-1:0] iv;
    logic         we;
    logic [1:0]   wa;
    logic [31:0]  wd;
    iv = in_port;
    we = bus_if.chipselect && !bus_if.write_n;
    wa = bus_if.address;
    wd = bus_if.writedata;
    @(posedge clk);
    model_step(iv, we, wa, wd);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    #1;
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    rd(2'd0, d);  chk({tag, "_data"}, d, {28'd0, stab_q[1]});
    rd(2'd1, d);  chk({tag, "_rsvd"}, d, 32'd0);
    rd(2'd2, d);  chk({tag, "_mask"}, d, {28'd0, m_mask});
    rd(2'd3, d);  chk({tag, "_edge"}, d, {28'd0, m_ecap});
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    #1;
    chk({tag, "_nocs"}, bus_if.readdata, 32'd0);
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;
    logic [31:0] exp_edge;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;
    int          n;
    bit          got;
    int          hold;

    vecs[0] = '{2'd2, 32'h0000_0005, 32'hF, 32'h5, 32'h0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF, 32'hF, 32'h5, 32'h0};
    vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'hF, 32'h5, 32'h0};
    vecs[3] = '{2'd2, 32'hFFFF_FFFA, 32'hF, 32'hA, 32'h0};
    vecs[4] = '{2'd3, 32'h0000_000F, 32'hF, 32'hA, 32'h0};
    vecs[5] = '{2'd2, 32'h0000_0000, 32'hF, 32'h0, 32'h0};

    // ---------------- clock/reset ----------------
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = 32'd0;
    model_reset();
    #1;
    chk("reset_readdata", bus_if.readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // ---------------- reset state ----------------
    rd(2'd0, d);  chk("init_data", d, 32'hF);
    rd(2'd2, d);  chk("init_mask", d, 32'h0);
    rd(2'd3, d);  chk("init_edge", d, 32'h0);
    ticks(LAT + 2);
    check_all("idle");

    // ---------------- register table ----------------
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      rd(2'd0, d);  chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      rd(2'd1, d);  chk($sformatf("vec%0d_rsvd", i), d, 32'd0);
      rd(2'd2, d);  chk($sformatf("vec%0d_mask", i), d, vecs[i].exp_mask);
      rd(2'd3, d);  chk($sformatf("vec%0d_edge", i), d, vecs[i].exp_edge);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
    end

    // ---------------- press latency, irq, clear ----------------
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    n = 0;  got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      rd(2'd3, d);
      if (d != 0) got = 1'b1;
    end
    chk("press_latency", n, LAT);
    chk("press_edge", d, 32'h1);
    chk("press_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("press_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h1);
    rd(2'd3, d);  chk("clear_edge", d, 32'h0);
    tick();
    chk("clear_irq", {31'd0, irq}, 32'd0);
    in_port = 4'hF;
    ticks(LAT + 3);
    rd(2'd3, d);  chk("release_no_edge", d, 32'h0);
    check_all("release");

`ifdef PB_INPUT_DEBOUNCE_EN
    // ---------------- glitch reject ----------------
    in_port = 4'hB;
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(2'd0, d);  chk("glitch_data_lo", d, 32'hF);
    end
    in_port = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      rd(2'd0, d);  chk("glitch_data", d, 32'hF);
    end
    rd(2'd3, d);  chk("glitch_edge", d, 32'h0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);
`endif

    // ---------------- masked capture then unmask ----------------
    bus_write(2'd2, 32'h0);
    in_port = 4'h7;
    ticks(LAT + 2);
    rd(2'd3, d);  chk("mask0_edge", d, 32'h8);
    chk("mask0_irq", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h8);
    chk("unmask_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("unmask_irq", {31'd0, irq}, 32'd1);

    // ---------------- same-cycle set and clear ----------------
    in_port = 4'hF;
    ticks(LAT + 3);
    bus_write(2'd3, 32'h8);
    rd(2'd3, d);  chk("pre_setclr_edge", d, 32'h0);
    in_port = 4'h7;
    ticks(LAT - 1);
    bus_write(2'd3, 32'h8);
    rd(2'd3, d);  chk("setclr_edge", d, 32'h8);
    check_all("setclr");

    // ---------------- reset mid-operation ----------------
    in_port = 4'h0;
    bus_write(2'd2, 32'hF);
    ticks(LAT + 2);
    rd(2'd3, d);  chk("all_edge", d, 32'hF);
    chk("all_irq", {31'd0, irq}, 32'd1);
    in_port = 4'hF;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, d);  chk("rst_edge_rd", d, 32'h0);
    rd(2'd2, d);  chk("rst_mask_rd", d, 32'h0);
    rd(2'd0, d);  chk("rst_data_rd", d, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    rd(2'd2, d);  chk("post_rst_mask", d, 32'h0);
    rd(2'd3, d);  chk("post_rst_edge", d, 32'h0);
    ticks(LAT + 3);
    rd(2'd3, d);  chk("post_rst_no_edge", d, 32'h0);
    check_all("post_rst");

    // ---------------- randomized run vs model ----------------
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom_range(0, 15));
        hold    = (DLAT != 0) ? $urandom_range(1, 14) : $urandom_range(1, 5);
      end
      hold--;
      case ($urandom_range(0, 11))
        0:       bus_write(2'd2, $urandom);
        1, 2:    bus_write(2'd3, $urandom);
        3:       bus_write(2'($urandom_range(0, 1)), $urandom);
        default: tick();
      endcase
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
